rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
Round-robin arbiter that shares one resource among NUM_REQ requesters, with lock-until-release grants and a bounded hold time.
- Arbitration is built around the existing priority_encoder, which returns the highest set index plus a valid flag.
- Fairness comes from masking the request vector below the last-granted index.
- Sits in front of any shared datapath, such as a bus port or a single encoder or ALU instance, and drives its select.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
MAX_HOLD, 4, max cycles a grant is held while others wait; 0 = no preemption
IDX_W, $clog2(NUM_REQ), grant index width (derived, not overridable)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  request vector; a requester holds its bit high for the whole transaction
gnt  output  NUM_REQ  one-hot grant, registered
gnt_idx  output  IDX_W  index of the granted requester, registered
gnt_valid  output  1  high when a grant is active, registered

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE, ptr=0, hold_cnt=0. Reset takes effect immediately, with no clock needed.
- FSM states: IDLE and GRANT.
- Arbitration function arb(v), used with the pointer ptr:
  - masked = v & ((1<<ptr)-1).
  - If masked!=0, winner = priority_encoder(masked); otherwise winner = priority_encoder(v).
  - Effective order is descending, starting at ptr-1 and wrapping to NUM_REQ-1. After reset (ptr=0) the highest index wins.
- IDLE:
  - If req!=0 at an edge: winner w=arb(req) and go to GRANT.
  - On entering GRANT: gnt=1<<w, gnt_idx=w, gnt_valid=1, ptr=w, hold_cnt=0.
  - Latency from req to gnt is 1 cycle.
- GRANT, release: req[gnt_idx]==0 at an edge.
  - If other=req&~gnt is nonzero: regrant to arb(other) on the same edge, with no idle bubble.
  - Otherwise go to IDLE and clear gnt, gnt_idx, gnt_valid.
- GRANT, preempt: MAX_HOLD>0, hold_cnt==MAX_HOLD-1, req[gnt_idx]==1 and other!=0.
  - Regrant to arb(other).
  - The preempted requester keeps its req high and re-competes normally.
- GRANT, otherwise:
  - Hold the grant and increment hold_cnt.
  - hold_cnt saturates at MAX_HOLD-1 when no other requester is waiting, so an uncontended holder is never dropped.
- hold_cnt width is $clog2(MAX_HOLD+1). Every new grant resets it to 0, so a contended grant is visible for exactly MAX_HOLD cycles.
- Changes on non-granted req bits never disturb the current grant.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_idx equals the set bit position.
- Release and preempt conditions cannot both be true on one edge; release takes priority by definition.
- ptr updates only when a new grant is issued.

Decomposition:
- arbiter_pkg holds:
  - state_e typedef {IDLE, GRANT}
  - function onehot(idx) returning NUM_REQ bits (parameterised via module-local use)
- Sub-module: one instance of priority_encoder #(.NUM_INPUTS(NUM_REQ)).
  - Fed with the mux of masked or unmasked request.
  - Its valid output selects masked vs unmasked, via a second instance or a shared-mux implementation; both are acceptable.
- The rest is one always_ff block plus combinational next-state logic; target 150-250 lines.

Test Plan (NUM_REQ=4, MAX_HOLD=4):
1. Reset: rst_n=0 asynchronously mid-cycle with req=4'b1111 -> gnt=0, gnt_idx=0, gnt_valid=0 immediately. After rst_n=1 and one edge -> gnt=4'b1000, gnt_idx=3.
2. Single requester: req=4'b0100 held 10 cycles -> gnt=4'b0100 from cycle 1 for all 10 cycles (no preemption). req=0 -> gnt=0, gnt_valid=0 one cycle later.
3. Round-robin rotation: req=4'b1111, each requester drops its bit for one cycle after 2 granted cycles -> grant order 3,2,1,0,3 with no idle cycle between grants.
4. Preemption: req=4'b1001 held constant -> gnt=4'b1000 for exactly 4 cycles, then 4'b0001 for 4 cycles, repeating.
5. Release plus new arrival on the same edge: holder idx 2 drops while req[1] rises -> gnt=4'b0010 next cycle. With ptr=2, a simultaneous req[3] loses to req[1].
6. Reset mid-grant: rst_n pulsed while gnt=4'b0010 -> outputs 0 and ptr=0. Then req=4'b0101 -> gnt=4'b0100.

Source files
------------

// File: rtl/arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_pkg
// Description : Shared types and helpers for the round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arbiter_pkg;

    localparam int c_onehot_w = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Wide one-hot; callers cast the result down to their requester count.
    function automatic logic [c_onehot_w-1:0] onehot(input int unsigned idx);
        return c_onehot_w'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder
// Description : Returns the highest set input index and a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder #(
    parameter int NUM_INPUTS = 4
) (
    input  logic [NUM_INPUTS-1:0]         i_req,
    output logic [$clog2(NUM_INPUTS)-1:0] o_idx,
    output logic                          o_valid
);

    localparam int c_idx_w = $clog2(NUM_INPUTS);

    // Ascending scan so the last hit, the highest index, wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (i_req[i]) begin
                o_idx   = c_idx_w'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with lock-until-release grants and a
//               bounded hold time under contention. NUM_REQ must be <= 32.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 4,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    localparam int                c_hold_w     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = (MAX_HOLD > 0) ? c_hold_w'(MAX_HOLD - 1) : '0;
    localparam logic              c_preempt_en = (MAX_HOLD > 0);

    state_e               r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic                 r_gnt_valid;
    logic [IDX_W-1:0]     r_ptr;
    logic [c_hold_w-1:0]  r_hold_cnt;

    state_e               w_state_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [IDX_W-1:0]     w_gnt_idx_nxt;
    logic                 w_gnt_valid_nxt;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic [c_hold_w-1:0]  w_hold_nxt;
    logic                 w_new_grant;
    logic                 w_go_idle;

    logic [NUM_REQ-1:0]   w_other;
    logic [NUM_REQ-1:0]   w_mask;
    logic [NUM_REQ-1:0]   w_masked;
    logic [IDX_W-1:0]     w_idx_masked;
    logic                 w_vld_masked;
    logic [IDX_W-1:0]     w_idx_full;
    logic                 w_vld_full;
    logic [IDX_W-1:0]     w_winner;

    // In IDLE r_gnt is zero, so this is simply req there.
    assign w_other = req & ~r_gnt;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (IDX_W'(i) < r_ptr);
        end
    end

    assign w_masked = w_other & w_mask;

    priority_encoder #(
        .NUM_INPUTS (NUM_REQ)
    ) u_pe_masked (
        .i_req   (w_masked),
        .o_idx   (w_idx_masked),
        .o_valid (w_vld_masked)
    );

    priority_encoder #(
        .NUM_INPUTS (NUM_REQ)
    ) u_pe_full (
        .i_req   (w_other),
        .o_idx   (w_idx_full),
        .o_valid (w_vld_full)
    );

    assign w_winner = w_vld_masked ? w_idx_masked : w_idx_full;

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold_cnt;
        w_new_grant     = 1'b0;
        w_go_idle       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_vld_full) w_new_grant = 1'b1;
            end
            GRANT: begin
                // Release outranks preemption; the holder dropping its bit ends the grant.
                if (!req[r_gnt_idx]) begin
                    if (w_vld_full) w_new_grant = 1'b1;
                    else            w_go_idle   = 1'b1;
                end else if (c_preempt_en && (r_hold_cnt == c_hold_last) && w_vld_full) begin
                    w_new_grant = 1'b1;
                end else if (r_hold_cnt != c_hold_last) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: w_go_idle = 1'b1;
        endcase

        if (w_new_grant) begin
            w_state_nxt     = GRANT;
            w_gnt_nxt       = NUM_REQ'(onehot(32'(w_winner)));
            w_gnt_idx_nxt   = w_winner;
            w_gnt_valid_nxt = 1'b1;
            w_ptr_nxt       = w_winner;
            w_hold_nxt      = '0;
        end else if (w_go_idle) begin
            w_state_nxt     = IDLE;
            w_gnt_nxt       = '0;
            w_gnt_idx_nxt   = '0;
            w_gnt_valid_nxt = 1'b0;
            w_hold_nxt      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter
// Description : Scoreboard bench for rr_arbiter with a rotation-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_valid;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [1:0]   idx;
        logic         valid;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    int m_holder = -1;
    int m_last   = 0;
    int m_held   = 0;

    always #5 clk = ~clk;

    rr_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    // Next requester in rotation order: last-1, last-2, ... wrapping around.
    function automatic int pick(input logic [N-1:0] v, input int last);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (last - k + N) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        exp_t         e;
        logic [N-1:0] others;
        if (!rst_n) begin
            m_holder = -1;
            m_last   = 0;
            m_held   = 0;
        end else if (m_holder < 0) begin
            if (req != '0) begin
                m_holder = pick(req, m_last);
                m_last   = m_holder;
                m_held   = 1;
            end
        end else begin
            others           = req;
            others[m_holder] = 1'b0;
            if (!req[m_holder] || (m_held >= MH && others != '0)) begin
                if (others != '0) begin
                    m_holder = pick(others, m_last);
                    m_last   = m_holder;
                    m_held   = 1;
                end else begin
                    m_holder = -1;
                end
            end else begin
                m_held++;
            end
        end
        e = '0;
        if (m_holder >= 0) begin
            e.gnt   = N'(1) << m_holder;
            e.idx   = 2'(m_holder);
            e.valid = 1'b1;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=none expected=entry t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (!rst_n) e = '0;
            check("sb_gnt",   32'(gnt),       32'(e.gnt));
            check("sb_idx",   32'(gnt_idx),   32'(e.idx));
            check("sb_valid", 32'(gnt_valid), 32'(e.valid));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_gnt"},   32'(gnt),       32'h0);
        check({name, "_idx"},   32'(gnt_idx),   32'h0);
        check({name, "_valid"}, 32'(gnt_valid), 32'h0);
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] ones;
        int           e_idx;
        ones = '1;

        step(2);
        rst_n = 1'b1;

        // Asynchronous reset mid-cycle, then the top index wins first.
        req = 4'b1111;
        step(2);
        #1 rst_n = 1'b0;
        #1 check_zero("async_rst");
        step();
        rst_n = 1'b1;
        step();
        check("rst_first_gnt", 32'(gnt),     32'h8);
        check("rst_first_idx", 32'(gnt_idx), 32'h3);

        // Uncontended holder is never dropped.
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            step();
            check("single_gnt", 32'(gnt), 32'h4);
        end
        req = '0;
        step();
        check("single_rel_gnt",   32'(gnt),       32'h0);
        check("single_rel_valid", 32'(gnt_valid), 32'h0);

        // Rotation with one-cycle drops, no idle bubble.
        do_reset();
        req = ones;
        step();
        for (int k = 0; k < 5; k++) begin
            e_idx = (7 - k) % 4;
            check("rot_idx",   32'(gnt_idx),   32'(e_idx));
            check("rot_valid", 32'(gnt_valid), 32'h1);
            step();
            req = ones & ~(N'(1) << e_idx);
            step();
            req = ones;
        end

        // Preemption alternates every MAX_HOLD cycles.
        do_reset();
        req = 4'b1001;
        for (int c = 0; c < 16; c++) begin
            step();
            check("preempt_gnt", 32'(gnt), (((c / MH) % 2) == 0) ? 32'h8 : 32'h1);
        end

        // Release with simultaneous arrivals: ptr=2 so req[1] beats req[3].
        req = '0;
        do_reset();
        req = 4'b0100;
        step();
        check("rel_hold_gnt", 32'(gnt), 32'h4);
        req = 4'b1010;
        step();
        check("rel_new_gnt", 32'(gnt), 32'h2);

        // Reset mid-grant clears the pointer too.
        #1 rst_n = 1'b0;
        #1 check_zero("midgrant_rst");
        req = 4'b0101;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_gnt", 32'(gnt), 32'h4);

        // Random traffic with occasional reset pulses.
        for (int c = 0; c < 600; c++) begin
            r = req;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if ($urandom_range(5) == 0) r[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    r[i] = 1'b1;
                end
            end
            req = r;
            if ($urandom_range(99) == 0) begin
                #1 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        req = '0;
        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
